game_state_ctrl: RTL and testbench

Frame-synchronous game sequencer for the Plants vs Zombies VGA design. It owns the one-hot game state (intro, three levels, two next-level banners, lose, win) and counts kills per level and in total. It decides when the gameplay renderer runs and which screen the top-level RGB mux shows. State changes are requested by events but committed only on a frame boundary, so a screen never switches mid-frame.

---
 rtl/game_state_ctrl_pkg.sv | 40 ++++
 rtl/game_state_ctrl_sat_counter.sv | 23 ++
 rtl/game_state_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
// game_pkg: one-hot game states, screen select codes and small decode helpers
// shared by the game sequencer and its bench.
package game_pkg;

   localparam logic [7:0] ST_I     = 8'b1000_0000;
   localparam logic [7:0] ST_L1    = 8'b0100_0000;
   localparam logic [7:0] ST_NL2   = 8'b0010_0000;
   localparam logic [7:0] ST_L2    = 8'b0001_0000;
   localparam logic [7:0] ST_NL3   = 8'b0000_1000;
   localparam logic [7:0] ST_L3    = 8'b0000_0100;
   localparam logic [7:0] ST_DONEL = 8'b0000_0010;
   localparam logic [7:0] ST_DONEW = 8'b0000_0001;

   typedef enum logic [7:0] {
      S_I     = ST_I,
      S_L1    = ST_L1,
      S_NL2   = ST_NL2,
      S_L2    = ST_L2,
      S_NL3   = ST_NL3,
      S_L3    = ST_L3,
      S_DONEL = ST_DONEL,
      S_DONEW = ST_DONEW
   } game_state_t;

   localparam logic [1:0] SCR_PLAY   = 2'd0;
   localparam logic [1:0] SCR_LOSE   = 2'd1;
   localparam logic [1:0] SCR_WIN    = 2'd2;
   localparam logic [1:0] SCR_BANNER = 2'd3;

   // True for the three gameplay states.
   function automatic logic is_level(input game_state_t s);
      return (s == S_L1) || (s == S_L2) || (s == S_L3);
   endfunction

   // True for states whose entry restarts the per-level kill and hold counts.
   function automatic logic is_play_or_banner(input game_state_t s);
      return is_level(s) || (s == S_NL2) || (s == S_NL3);
   endfunction

endpackage

// File: rtl/game_state_ctrl_sat_counter.sv
// sat_counter: synchronous-clear, increment-by-one counter that sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment stops at the maximum value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-synchronous game sequencer. Events register a single
// pending target state; the target is committed only on a frame_tick so the
// visible screen never changes mid-frame.
// Build option: define LEVEL3_EN to enable the NL3/L3 stage; otherwise clearing
// level 2 goes straight to the win screen.
//
// state  | meaning
// S_I     | intro banner, waiting for select
// S_L1    | level 1 gameplay
// S_NL2   | banner before level 2 (select or hold timeout advances)
// S_L2    | level 2 gameplay
// S_NL3   | banner before level 3
// S_L3    | level 3 gameplay
// S_DONEL | lose screen
// S_DONEW | win screen
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned KILLS_L1       = 10,
   parameter int unsigned KILLS_L2       = 20,
   parameter int unsigned KILLS_L3       = 30,
   parameter logic [7:0]  NL_HOLD_FRAMES = 8'd180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        select_pulse,
   input  logic        frame_tick,
   input  logic        zombie_killed,
   input  logic        zombie_breach,
   output logic [7:0]  state,
   output logic [1:0]  level,
   output logic        play_en,
   output logic [1:0]  screen_sel,
   output logic        level_clear,
   output logic [7:0]  level_kills,
   output logic [15:0] zombies_killed
);

   game_state_t state_q;
   game_state_t next_q;
   game_state_t req_target;
   game_state_t win_target;
   logic        pending;
   logic        req;
   logic        commit;
   logic        in_level;
   logic        hold_done;
   logic        kill_hit;
   logic        kill_inc;
   logic        lk_clr;
   logic        zk_clr;
   logic [7:0]  hold_cnt;
   int unsigned kills_target;

   assign in_level  = is_level(state_q);
   assign play_en   = in_level && !pending;
   assign commit    = frame_tick && pending;
   assign hold_done = frame_tick && (hold_cnt == NL_HOLD_FRAMES - 8'd1);
   assign kill_hit  = zombie_killed && ((32'(level_kills) + 32'd1) == kills_target);
   // A kill in the breach cycle is lost with the level, so it is not counted.
   assign kill_inc  = zombie_killed && play_en && !zombie_breach;
   assign lk_clr    = commit && is_play_or_banner(next_q);
   assign zk_clr    = commit && (state_q == S_I) && (next_q == S_L1);
   assign state     = state_q;

   // Event stage: decide which target state, if any, the current inputs request.
   always_comb begin
      req          = 1'b0;
      req_target   = state_q;
      kills_target = KILLS_L1;
      win_target   = S_NL2;
      case (state_q)
         S_I: begin
            if (select_pulse) begin
               req        = 1'b1;
               req_target = S_L1;
            end
         end
         S_L1: begin
            kills_target = KILLS_L1;
            win_target   = S_NL2;
         end
         S_L2: begin
            kills_target = KILLS_L2;
`ifdef LEVEL3_EN
            win_target   = S_NL3;
`else
            win_target   = S_DONEW;
`endif
         end
         S_L3: begin
            kills_target = KILLS_L3;
            win_target   = S_DONEW;
         end
         S_NL2: begin
            if (select_pulse || hold_done) begin
               req        = 1'b1;
               req_target = S_L2;
            end
         end
         S_NL3: begin
            if (select_pulse || hold_done) begin
               req        = 1'b1;
               req_target = S_L3;
            end
         end
         S_DONEL, S_DONEW: begin
            if (select_pulse) begin
               req        = 1'b1;
               req_target = S_I;
            end
         end
         default: ;
      endcase
      if (in_level) begin
         if (zombie_breach) begin
            req        = 1'b1;
            req_target = S_DONEL;
         end else if (kill_hit) begin
            req        = 1'b1;
            req_target = win_target;
         end
      end
   end

   // Pending request register and frame-boundary commit of the game state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_I;
         next_q      <= S_I;
         pending     <= 1'b0;
         level_clear <= 1'b0;
      end else begin
         level_clear <= 1'b0;
         if (commit) begin
            state_q     <= next_q;
            pending     <= 1'b0;
            level_clear <= in_level &&
                           ((next_q == S_NL2) || (next_q == S_NL3) || (next_q == S_DONEW));
         end else if (req && !pending) begin
            pending <= 1'b1;
            next_q  <= req_target;
         end
      end
   end

   // Banner hold counter: counts frames while a next-level banner is shown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= 8'd0;
      end else if (lk_clr) begin
         hold_cnt <= 8'd0;
      end else if (frame_tick && ((state_q == S_NL2) || (state_q == S_NL3)) &&
                   (hold_cnt != NL_HOLD_FRAMES)) begin
         hold_cnt <= hold_cnt + 8'd1;
      end
   end

   // Screen and level decode from the registered state.
   always_comb begin
      level      = 2'd0;
      screen_sel = SCR_BANNER;
      case (state_q)
         S_L1:    begin level = 2'd1; screen_sel = SCR_PLAY;   end
         S_NL2:   begin level = 2'd2; screen_sel = SCR_BANNER; end
         S_L2:    begin level = 2'd2; screen_sel = SCR_PLAY;   end
         S_NL3:   begin level = 2'd3; screen_sel = SCR_BANNER; end
         S_L3:    begin level = 2'd3; screen_sel = SCR_PLAY;   end
         S_DONEL: begin level = 2'd0; screen_sel = SCR_LOSE;   end
         S_DONEW: begin level = 2'd0; screen_sel = SCR_WIN;    end
         default: begin level = 2'd0; screen_sel = SCR_BANNER; end
      endcase
   end

   sat_counter #(.W(8)) u_level_kills (
      .clk   (clk),
      .reset (reset),
      .clr   (lk_clr),
      .inc   (kill_inc),
      .count (level_kills)
   );

   sat_counter #(.W(16)) u_zombies_killed (
      .clk   (clk),
      .reset (reset),
      .clr   (zk_clr),
      .inc   (kill_inc),
      .count (zombies_killed)
   );

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl (default build, level 3 disabled). Expected
// outputs are queued when a cycle is driven and compared one clock later.
module tb_game_state_ctrl;

   logic        clk;
   logic        reset;
   logic        select_pulse;
   logic        frame_tick;
   logic        zombie_killed;
   logic        zombie_breach;
   logic [7:0]  state;
   logic [1:0]  level;
   logic        play_en;
   logic [1:0]  screen_sel;
   logic        level_clear;
   logic [7:0]  level_kills;
   logic [15:0] zombies_killed;

   game_state_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .select_pulse   (select_pulse),
      .frame_tick     (frame_tick),
      .zombie_killed  (zombie_killed),
      .zombie_breach  (zombie_breach),
      .state          (state),
      .level          (level),
      .play_en        (play_en),
      .screen_sel     (screen_sel),
      .level_clear    (level_clear),
      .level_kills    (level_kills),
      .zombies_killed (zombies_killed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  st;
      logic [1:0]  lvl;
      logic        pe;
      logic [1:0]  scr;
      logic        lc;
      logic [7:0]  lk;
      logic [15:0] zk;
   } exp_t;

   typedef struct {
      logic        sel;
      logic        tick;
      logic        kill;
      logic        breach;
      logic [7:0]  st;
      logic        pe;
      logic        lc;
      logic [7:0]  lk;
      logic [15:0] zk;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;

   // Level and screen codes as listed in the interface table.
   function automatic exp_t mk(input logic [7:0] st, input logic pe, input logic lc,
                               input logic [7:0] lk, input logic [15:0] zk);
      exp_t e;
      e.st = st; e.pe = pe; e.lc = lc; e.lk = lk; e.zk = zk;
      case (st)
         8'h40:   begin e.lvl = 2'd1; e.scr = 2'd0; end
         8'h20:   begin e.lvl = 2'd2; e.scr = 2'd3; end
         8'h10:   begin e.lvl = 2'd2; e.scr = 2'd0; end
         8'h08:   begin e.lvl = 2'd3; e.scr = 2'd3; end
         8'h04:   begin e.lvl = 2'd3; e.scr = 2'd0; end
         8'h02:   begin e.lvl = 2'd0; e.scr = 2'd1; end
         8'h01:   begin e.lvl = 2'd0; e.scr = 2'd2; end
         default: begin e.lvl = 2'd0; e.scr = 2'd3; end
      endcase
      return e;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d actual %h required %h", nm, step, act, req);
      end
   endtask

   task automatic compare(input exp_t e);
      chk("state",          {8'd0, state},       {8'd0, e.st});
      chk("level",          {14'd0, level},      {14'd0, e.lvl});
      chk("play_en",        {15'd0, play_en},    {15'd0, e.pe});
      chk("screen_sel",     {14'd0, screen_sel}, {14'd0, e.scr});
      chk("level_clear",    {15'd0, level_clear},{15'd0, e.lc});
      chk("level_kills",    {8'd0, level_kills}, {8'd0, e.lk});
      chk("zombies_killed", zombies_killed,      e.zk);
   endtask

   // Drive one clock of inputs, queue the expectation, compare after the edge.
   task automatic cyc(input logic s, input logic t, input logic k, input logic b,
                      input logic [7:0] st, input logic pe, input logic lc,
                      input logic [7:0] lk, input logic [15:0] zk);
      exp_t e;
      select_pulse  = s;
      frame_tick    = t;
      zombie_killed = k;
      zombie_breach = b;
      sb.push_back(mk(st, pe, lc, lk, zk));
      @(posedge clk);
      #1;
      select_pulse  = 1'b0;
      frame_tick    = 1'b0;
      zombie_killed = 1'b0;
      zombie_breach = 1'b0;
      step++;
      e = sb.pop_front();
      compare(e);
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{sel:0, tick:0, kill:0, breach:0, st:8'h80, pe:0, lc:0, lk:0, zk:0};
      tbl[1] = '{sel:1, tick:0, kill:0, breach:0, st:8'h80, pe:0, lc:0, lk:0, zk:0};
      tbl[2] = '{sel:0, tick:1, kill:0, breach:0, st:8'h40, pe:1, lc:0, lk:0, zk:0};
      tbl[3] = '{sel:0, tick:0, kill:1, breach:0, st:8'h40, pe:1, lc:0, lk:1, zk:1};
      tbl[4] = '{sel:0, tick:1, kill:1, breach:0, st:8'h40, pe:1, lc:0, lk:2, zk:2};
      tbl[5] = '{sel:1, tick:0, kill:0, breach:0, st:8'h40, pe:1, lc:0, lk:2, zk:2};

      reset         = 1'b1;
      select_pulse  = 1'b0;
      frame_tick    = 1'b0;
      zombie_killed = 1'b0;
      zombie_breach = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compare(mk(8'h80, 1'b0, 1'b0, 8'd0, 16'd0));
      reset = 1'b0;

      // Intro to L1 and first kills.
      foreach (tbl[i])
         cyc(tbl[i].sel, tbl[i].tick, tbl[i].kill, tbl[i].breach,
             tbl[i].st, tbl[i].pe, tbl[i].lc, tbl[i].lk, tbl[i].zk);

      // Kills 3..10: the tenth requests NL2 and drops play_en.
      for (int k = 3; k <= 10; k++)
         cyc(0, 0, 1, 0, 8'h40, (k < 10), 0, 8'(k), 16'(k));
      cyc(0, 0, 1, 0, 8'h40, 0, 0, 8'd10, 16'd10);
      cyc(0, 1, 0, 0, 8'h20, 0, 1, 8'd0, 16'd10);
      cyc(0, 0, 0, 0, 8'h20, 0, 0, 8'd0, 16'd10);

      // Banner hold: 180 frames, commit on the 181st.
      for (int i = 1; i <= 180; i++) begin
         cyc(0, 1, 0, 0, 8'h20, 0, 0, 8'd0, 16'd10);
         cyc(0, 0, 0, 0, 8'h20, 0, 0, 8'd0, 16'd10);
      end
      cyc(0, 1, 0, 0, 8'h10, 1, 0, 8'd0, 16'd10);

      // L2: 19 kills, then kill and breach together -> DoneL, kill not counted.
      for (int k = 1; k <= 19; k++)
         cyc(0, 0, 1, 0, 8'h10, 1, 0, 8'(k), 16'(10 + k));
      cyc(0, 0, 1, 1, 8'h10, 0, 0, 8'd19, 16'd29);
      cyc(0, 1, 0, 0, 8'h02, 0, 0, 8'd19, 16'd29);
      cyc(1, 0, 0, 0, 8'h02, 0, 0, 8'd19, 16'd29);
      cyc(0, 1, 0, 0, 8'h80, 0, 0, 8'd19, 16'd29);
      cyc(1, 0, 0, 0, 8'h80, 0, 0, 8'd19, 16'd29);
      cyc(0, 1, 0, 0, 8'h40, 1, 0, 8'd0, 16'd0);

      // Breach on a frame tick: no commit on that tick, DoneL on the next.
      cyc(0, 1, 0, 1, 8'h40, 0, 0, 8'd0, 16'd0);
      cyc(0, 0, 1, 0, 8'h40, 0, 0, 8'd0, 16'd0);
      cyc(0, 1, 0, 0, 8'h02, 0, 0, 8'd0, 16'd0);
      cyc(1, 0, 0, 0, 8'h02, 0, 0, 8'd0, 16'd0);
      cyc(0, 1, 0, 0, 8'h80, 0, 0, 8'd0, 16'd0);
      cyc(1, 0, 0, 0, 8'h80, 0, 0, 8'd0, 16'd0);
      cyc(0, 1, 0, 0, 8'h40, 1, 0, 8'd0, 16'd0);

      // L1 cleared again, select skips the banner hold, L2 cleared -> DoneW.
      for (int k = 1; k <= 10; k++)
         cyc(0, 0, 1, 0, 8'h40, (k < 10), 0, 8'(k), 16'(k));
      cyc(0, 1, 0, 0, 8'h20, 0, 1, 8'd0, 16'd10);
      cyc(1, 0, 0, 0, 8'h20, 0, 0, 8'd0, 16'd10);
      cyc(0, 1, 0, 0, 8'h10, 1, 0, 8'd0, 16'd10);
      for (int k = 1; k <= 20; k++)
         cyc(0, 0, 1, 0, 8'h10, (k < 20), 0, 8'(k), 16'(10 + k));
      cyc(0, 1, 0, 0, 8'h01, 0, 1, 8'd20, 16'd30);
      cyc(0, 0, 0, 0, 8'h01, 0, 0, 8'd20, 16'd30);
      cyc(1, 0, 0, 0, 8'h01, 0, 0, 8'd20, 16'd30);
      cyc(0, 1, 0, 0, 8'h80, 0, 0, 8'd20, 16'd30);

      // Asynchronous reset with a request pending.
      cyc(1, 0, 0, 0, 8'h80, 0, 0, 8'd20, 16'd30);
      cyc(0, 1, 0, 0, 8'h40, 1, 0, 8'd0, 16'd0);
      cyc(0, 0, 1, 0, 8'h40, 1, 0, 8'd1, 16'd1);
      cyc(0, 0, 0, 1, 8'h40, 0, 0, 8'd1, 16'd1);
      #1;
      reset = 1'b1;
      #1;
      step++;
      compare(mk(8'h80, 1'b0, 1'b0, 8'd0, 16'd0));
      #1;
      reset = 1'b0;
      cyc(0, 1, 0, 0, 8'h80, 0, 0, 8'd0, 16'd0);
      cyc(0, 1, 0, 0, 8'h80, 0, 0, 8'd0, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
